// File: rtl/alu_rr_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// Optional ALU_RR_ARBITER_ZERO_FLAG_EN adds a registered res_zero flag alongside res_data.
module alu_rr_arbiter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH:0]   req0_sel,
    input  logic             req0_cin,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH:0]   req1_sel,
    input  logic             req1_cin,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic             alu_cin,
    output logic [WIDTH:0]   alu_sel,
    input  logic [WIDTH-1:0] alu_y,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             res_id,
`ifdef ALU_RR_ARBITER_ZERO_FLAG_EN
    output logic             busy,
    output logic             res_zero
`else
    output logic             busy
`endif
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t           state_q, state_d;
    logic             last_grant_q, last_grant_d;
    logic [WIDTH-1:0] alu_a_q, alu_a_d;
    logic [WIDTH-1:0] alu_b_q, alu_b_d;
    logic             alu_cin_q, alu_cin_d;
    logic [WIDTH:0]   alu_sel_q, alu_sel_d;
    logic [WIDTH-1:0] res_data_q, res_data_d;
    logic             res_id_q, res_id_d;
    logic             zero_q, zero_d;
    logic             gnt0, gnt1;

    // On a tie the requester that did not win last time goes first.
    assign gnt0 = req0_valid & (~req1_valid | last_grant_q);
    assign gnt1 = req1_valid & ~gnt0;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_cin_d    = alu_cin_q;
        alu_sel_d    = alu_sel_q;
        res_data_d   = res_data_q;
        res_id_d     = res_id_q;
        zero_d       = zero_q;
        case (state_q)
            IDLE: begin
                if (gnt0 | gnt1) begin
                    alu_a_d      = gnt1 ? req1_a   : req0_a;
                    alu_b_d      = gnt1 ? req1_b   : req0_b;
                    alu_cin_d    = gnt1 ? req1_cin : req0_cin;
                    alu_sel_d    = gnt1 ? req1_sel : req0_sel;
                    res_id_d     = gnt1;
                    last_grant_d = gnt1;
                    state_d      = EXEC;
                end
            end
            EXEC: begin
                res_data_d = alu_y;
                zero_d     = (alu_y == '0);
                state_d    = RESP;
            end
            RESP: begin
                if (res_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_cin_q    <= 1'b0;
            alu_sel_q    <= '0;
            res_data_q   <= '0;
            res_id_q     <= 1'b0;
            zero_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_cin_q    <= alu_cin_d;
            alu_sel_q    <= alu_sel_d;
            res_data_q   <= res_data_d;
            res_id_q     <= res_id_d;
            zero_q       <= zero_d;
        end
    end

    // Ready is gated by rst_n so nothing looks accepted while reset is held.
    assign req0_ready = rst_n & (state_q == IDLE) & gnt0;
    assign req1_ready = rst_n & (state_q == IDLE) & gnt1;
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_cin    = alu_cin_q;
    assign alu_sel    = alu_sel_q;
    assign res_valid  = (state_q == RESP);
    assign res_data   = res_data_q;
    assign res_id     = res_id_q;
    assign busy       = (state_q != IDLE);
`ifdef ALU_RR_ARBITER_ZERO_FLAG_EN
    assign res_zero   = zero_q;
`else
    logic unused_zero;
    assign unused_zero = zero_q;
`endif

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Directed bench for alu_rr_arbiter with a small combinational ALU model.
// Honours ALU_RR_ARBITER_ZERO_FLAG_EN for the res_zero port.
module tb_alu_rr_arbiter;
    localparam int WIDTH = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             req0_valid, req0_ready, req0_cin;
    logic [WIDTH:0]   req0_sel;
    logic [WIDTH-1:0] req0_a, req0_b;
    logic             req1_valid, req1_ready, req1_cin;
    logic [WIDTH:0]   req1_sel;
    logic [WIDTH-1:0] req1_a, req1_b;
    logic [WIDTH-1:0] alu_a, alu_b, alu_y, res_data;
    logic             alu_cin, res_valid, res_ready, res_id, busy;
    logic [WIDTH:0]   alu_sel;
`ifdef ALU_RR_ARBITER_ZERO_FLAG_EN
    logic             res_zero;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Shared ALU: add, subtract, and, or, xor; anything else yields 0.
    always_comb begin
        alu_y = '0;
        case (alu_sel)
            5'b00001: alu_y = alu_a + alu_b + {3'b000, alu_cin};
            5'b00010: alu_y = alu_a - alu_b;
            5'b00100: alu_y = alu_a & alu_b;
            5'b01000: alu_y = alu_a | alu_b;
            5'b10000: alu_y = alu_a ^ alu_b;
            default:  alu_y = '0;
        endcase
    end

    alu_rr_arbiter #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_sel(req0_sel),
        .req0_cin(req0_cin), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_sel(req1_sel),
        .req1_cin(req1_cin), .req1_a(req1_a), .req1_b(req1_b),
        .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin), .alu_sel(alu_sel),
        .alu_y(alu_y), .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_id(res_id),
`ifdef ALU_RR_ARBITER_ZERO_FLAG_EN
        .busy(busy), .res_zero(res_zero)
`else
        .busy(busy)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Leave 1 time unit after the rising edge so outputs have settled.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; res_ready = 1'b0;
        req0_valid = 1'b1; req0_sel = 5'b00001; req0_cin = 1'b0; req0_a = 4'd3; req0_b = 4'd5;
        req1_valid = 1'b0; req1_sel = '0; req1_cin = 1'b0; req1_a = '0; req1_b = '0;
        #1;
        check("rst_ready0", 32'(req0_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_alu_a", 32'(alu_a), 32'd0);
        check("rst_alu_sel", 32'(alu_sel), 32'd0);
        check("rst_res_data", 32'(res_data), 32'd0);
        check("rst_res_id", 32'(res_id), 32'd0);
        req0_valid = 1'b0;
        #21 rst_n = 1'b1;

        // 1: single add 3+5
        tick();
        req0_valid = 1'b1; req0_sel = 5'b00001; req0_cin = 1'b0; req0_a = 4'd3; req0_b = 4'd5;
        #1;
        check("t1_ready0", 32'(req0_ready), 32'd1);
        check("t1_ready1", 32'(req1_ready), 32'd0);
        tick();
        req0_valid = 1'b0;
        #1;
        check("t1_busy", 32'(busy), 32'd1);
        check("t1_noresp_yet", 32'(res_valid), 32'd0);
        check("t1_alu_a", 32'(alu_a), 32'd3);
        check("t1_alu_b", 32'(alu_b), 32'd5);
        check("t1_alu_sel", 32'(alu_sel), 32'd1);
        check("t1_ready_exec", 32'(req0_ready), 32'd0);
        tick();
        check("t1_res_valid", 32'(res_valid), 32'd1);
        check("t1_res_data", 32'(res_data), 32'd8);
        check("t1_res_id", 32'(res_id), 32'd0);
        res_ready = 1'b1;
        tick();
        check("t1_idle_valid", 32'(res_valid), 32'd0);
        check("t1_idle_busy", 32'(busy), 32'd0);

        // 2: both valid every cycle after a fresh reset -> 0,1,0,1
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        req0_valid = 1'b1; req0_sel = 5'b00001; req0_cin = 1'b0; req0_a = 4'd2; req0_b = 4'd3;
        req1_valid = 1'b1; req1_sel = 5'b00001; req1_cin = 1'b0; req1_a = 4'd7; req1_b = 4'd8;
        res_ready = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t2_ready0_%0d", i), 32'(req0_ready), 32'((i % 2) == 0));
            check($sformatf("t2_ready1_%0d", i), 32'(req1_ready), 32'((i % 2) == 1));
            tick();
            tick();
            check($sformatf("t2_valid_%0d", i), 32'(res_valid), 32'd1);
            check($sformatf("t2_id_%0d", i), 32'(res_id), 32'(i % 2));
            check($sformatf("t2_data_%0d", i), 32'(res_data), ((i % 2) == 0) ? 32'd5 : 32'd15);
            tick();
        end
        req0_valid = 1'b0; req1_valid = 1'b0; res_ready = 1'b0;

        // 3: req1 AND with stalled consumer; hold for 5 cycles
        tick();
        req1_valid = 1'b1; req1_sel = 5'b00100; req1_cin = 1'b0; req1_a = 4'b1100; req1_b = 4'b1010;
        #1;
        check("t3_ready1", 32'(req1_ready), 32'd1);
        tick();
        req1_a = 4'b0001; req1_b = 4'b0001; req0_valid = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) begin
            check($sformatf("t3_valid_%0d", i), 32'(res_valid), 32'd1);
            check($sformatf("t3_data_%0d", i), 32'(res_data), 32'b1000);
            check($sformatf("t3_id_%0d", i), 32'(res_id), 32'd1);
            check($sformatf("t3_noready_%0d", i), 32'({req0_ready, req1_ready}), 32'd0);
            tick();
        end
        req0_valid = 1'b0; req1_valid = 1'b0; res_ready = 1'b1;
        tick();
        check("t3_done", 32'(busy), 32'd0);
        res_ready = 1'b0;

        // 4: 15+0+1 wraps to 0
        req0_valid = 1'b1; req0_sel = 5'b00001; req0_cin = 1'b1; req0_a = 4'd15; req0_b = 4'd0;
        tick();
        req0_valid = 1'b0;
        tick();
        check("t4_valid", 32'(res_valid), 32'd1);
        check("t4_wrap", 32'(res_data), 32'd0);
`ifdef ALU_RR_ARBITER_ZERO_FLAG_EN
        check("t4_zero", 32'(res_zero), 32'd1);
`endif
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;

        // 6: req1 pulsed during RESP is never granted
        req0_valid = 1'b1; req0_sel = 5'b10000; req0_cin = 1'b0; req0_a = 4'd5; req0_b = 4'd3;
        tick();
        req0_valid = 1'b0;
        tick();
        req1_valid = 1'b1; req1_sel = 5'b00001; req1_a = 4'd1; req1_b = 4'd1;
        #1;
        check("t6_no_ready1", 32'(req1_ready), 32'd0);
        tick();
        req1_valid = 1'b0;
        check("t6_data", 32'(res_data), 32'd6);
        check("t6_id", 32'(res_id), 32'd0);
        res_ready = 1'b1;
        tick();
        check("t6_idle", 32'(busy), 32'd0);
        tick();
        tick();
        check("t6_no_extra", 32'(res_valid), 32'd0);
        check("t6_no_busy", 32'(busy), 32'd0);
        res_ready = 1'b0;

        // 5: reset during EXEC, then tie goes to requester 0
        req0_valid = 1'b1; req0_sel = 5'b00001; req0_cin = 1'b0; req0_a = 4'd9; req0_b = 4'd1;
        tick();
        req0_valid = 1'b0;
        check("t5_exec_busy", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("t5_rst_valid", 32'(res_valid), 32'd0);
        check("t5_rst_busy", 32'(busy), 32'd0);
        check("t5_rst_alu_a", 32'(alu_a), 32'd0);
        #1 rst_n = 1'b1;
        req0_valid = 1'b1; req0_sel = 5'b00001; req0_a = 4'd4; req0_b = 4'd4;
        req1_valid = 1'b1; req1_sel = 5'b00001; req1_a = 4'd1; req1_b = 4'd1;
        #1;
        check("t5_tie_ready0", 32'(req0_ready), 32'd1);
        check("t5_tie_ready1", 32'(req1_ready), 32'd0);
        tick();
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick();
        check("t5_valid", 32'(res_valid), 32'd1);
        check("t5_id", 32'(res_id), 32'd0);
        check("t5_data", 32'(res_data), 32'd8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
